// File: rtl/maxnet_job_sequencer_pkg.sv
// Shared definitions for the Maxnet job sequencer: FSM state encoding and default widths.
package maxnet_job_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/maxnet_job_sequencer_rise_detect.sv
// Rising-edge detector for a level input. The history flop resets to 1 so that a
// level already high when reset is released is not reported as an edge.
module maxnet_job_sequencer_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic in_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) in_q <= 1'b1;
    else      in_q <= in;
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/maxnet_job_sequencer.sv
// Initiator side of the Maxnet core start/done handshake: accepts a job, pulses
// core_start, waits for done (or times out) and hands the captured maximum downstream.
module maxnet_job_sequencer
  import maxnet_job_sequencer_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int START_HOLD = 10,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  output logic              core_start,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_max,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_timeout,
  output logic              busy,
  output logic [CNT_W-1:0]  job_count
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(START_HOLD - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             done_seen;
  logic             done_rise;

  maxnet_job_sequencer_rise_detect u_done_rise (
    .clk  (clk),
    .rst  (rst),
    .in   (core_done),
    .rise (done_rise)
  );

  assign busy      = (state != S_IDLE);
  assign req_ready = (state == S_IDLE);

  // One counter serves both the start-hold window and the done timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      done_seen   <= 1'b0;
      core_start  <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_timeout <= 1'b0;
      job_count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cnt        <= '0;
            done_seen  <= 1'b0;
            core_start <= 1'b1;
            state      <= S_START;
          end
        end
        S_START: begin
          if (done_rise) done_seen <= 1'b1;
          if (cnt == HOLD_LAST) begin
            core_start <= 1'b0;
            cnt        <= '0;
            // A done edge seen while start was held (including this cycle) completes the job.
            if (done_seen || done_rise) begin
              res_data    <= core_max;
              res_timeout <= 1'b0;
              res_valid   <= 1'b1;
              state       <= S_RESP;
            end else begin
              state <= S_WAIT;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (done_rise) begin
            res_data    <= core_max;
            res_timeout <= 1'b0;
            res_valid   <= 1'b1;
            state       <= S_RESP;
          end else if (cnt == TO_LAST) begin
            res_data    <= '0;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            state       <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            job_count <= job_count + 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_job_sequencer.sv
// Directed bench for maxnet_job_sequencer: table of jobs plus hand-written reset sequences.
module tb_maxnet_job_sequencer;

  localparam int DATA_W = 32;
  localparam int SH     = 10;
  localparam int TO     = 64;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              core_start;
  logic              core_done;
  logic [DATA_W-1:0] core_max;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_timeout;
  logic              busy;
  logic [CNT_W-1:0]  job_count;

  int checks = 0;
  int errors = 0;
  int exp_jobs = 0;

  always #5 clk = ~clk;

  maxnet_job_sequencer #(
    .DATA_W(DATA_W), .START_HOLD(SH), .TIMEOUT(TO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .core_start(core_start), .core_done(core_done), .core_max(core_max),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_timeout(res_timeout), .busy(busy), .job_count(job_count)
  );

  typedef struct {
    int          pre_done;     // core_done level presented at accept
    int          done_at;      // cycle index k at which core_done is driven high (-1: never)
    logic [31:0] max;
    int          ready_delay;  // cycles of res_ready=0 once the result is visible
    int          exp_lat;      // k at which res_valid is first observed
    logic        exp_to;
    logic [31:0] exp_data;
  } job_t;

  job_t jobs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge after the handshake.
  task automatic run_job(input int idx);
    job_t r;
    int   k;
    int   lat;
    int   starts;
    r = jobs[idx];
    req_valid = 1'b1;
    res_ready = 1'b0;
    core_done = (r.pre_done != 0);
    core_max  = r.max;
    chk($sformatf("j%0d_req_ready", idx), req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk($sformatf("j%0d_busy", idx), busy, 1);
    lat = -1;
    starts = 0;
    k = 0;
    while (k < 200) begin
      if (core_start) starts++;
      if (res_valid) begin
        lat = k;
        break;
      end
      if (r.done_at >= 0 && k >= r.done_at) core_done = 1'b1;
      core_max = (k < r.exp_lat) ? r.max : ~r.max;
      @(negedge clk);
      k++;
    end
    chk($sformatf("j%0d_latency", idx), lat, r.exp_lat);
    chk($sformatf("j%0d_start_cycles", idx), starts, SH);
    chk($sformatf("j%0d_res_data", idx), res_data, r.exp_data);
    chk($sformatf("j%0d_res_timeout", idx), res_timeout, r.exp_to);
    core_max = ~r.max;
    for (int j = 0; j < r.ready_delay; j++) begin
      req_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("j%0d_bp_valid", idx), res_valid, 1);
      chk($sformatf("j%0d_bp_data", idx), res_data, r.exp_data);
      chk($sformatf("j%0d_bp_req_ready", idx), req_ready, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    req_valid = 1'b0;
    exp_jobs++;
    chk($sformatf("j%0d_valid_drop", idx), res_valid, 0);
    chk($sformatf("j%0d_idle", idx), busy, 0);
    chk($sformatf("j%0d_no_reaccept", idx), core_start, 0);
    chk($sformatf("j%0d_job_count", idx), job_count, exp_jobs);
  endtask

  initial begin
    jobs[0] = '{0, 49, 32'h0000_00A7, 0, 50, 1'b0, 32'h0000_00A7}; // basic: done 40 cycles after start falls
    jobs[1] = '{1, -1, 32'hDEAD_BEEF, 0, SH+TO, 1'b1, 32'h0};      // done still high from job 0
    jobs[2] = '{0, 20, 32'h1234_5678, 15, 21, 1'b0, 32'h1234_5678}; // backpressure
    jobs[3] = '{0, 4, 32'h0000_0055, 0, SH, 1'b0, 32'h0000_0055};   // done rises during START
    jobs[4] = '{0, 73, 32'hCAFE_F00D, 0, SH+TO, 1'b0, 32'hCAFE_F00D}; // done and timeout together
    jobs[5] = '{0, -1, 32'h7777_7777, 0, SH+TO, 1'b1, 32'h0};       // plain timeout
    jobs[6] = '{0, 9, 32'h0000_0101, 0, SH, 1'b0, 32'h0000_0101};   // rise on the last START edge
    jobs[7] = '{0, 10, 32'h0000_0202, 0, SH+1, 1'b0, 32'h0000_0202}; // rise on the first WAIT edge

    rst = 1'b0; req_valid = 1'b0; core_done = 1'b0; core_max = '0; res_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_timeout", res_timeout, 0);
    chk("rst_job_count", job_count, 0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) run_job(i);

    // Reset mid-START: core_start must fall without waiting for a clock edge.
    req_valid = 1'b1;
    core_done = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_start_core_start", core_start, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_start_core_start", core_start, 0);
    chk("rst_start_busy", busy, 0);
    chk("rst_start_job_count", job_count, 0);
    @(negedge clk);
    rst = 1'b1;
    exp_jobs = 0;
    @(negedge clk);
    chk("rel_start_req_ready", req_ready, 1);

    // Reset mid-WAIT, then a full job must behave normally.
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid_wait_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_wait_busy", busy, 0);
    chk("rst_wait_res_valid", res_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_wait_req_ready", req_ready, 1);
    chk("rel_wait_job_count", job_count, 0);
    chk("rel_wait_core_start", core_start, 0);
    run_job(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
